// File: rtl/frame_pixel_streamer_if.sv
// Pixel streamer bus: frame RAM read port, pixel stream with framing markers, and control.
// The master side is the streamer; the slave side is the RAM/downstream/controller environment.
interface frame_pixel_streamer_if #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                          start;
  logic                          stall;
  logic                          mem_rd_en;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_rd_data;
  logic [DATA_WIDTH-1:0]         data_out;
  logic                          data_enable;
  logic                          sof;
  logic                          eol;
  logic                          eof;
  logic [$clog2(IMG_HEIGHT)-1:0] row;
  logic [$clog2(IMG_WIDTH)-1:0]  col;
  logic                          window_valid;
  logic                          busy;
  logic                          done;

  modport master (
    input  start, stall, mem_rd_data,
    output mem_rd_en, mem_addr, data_out, data_enable, sof, eol, eof,
           row, col, window_valid, busy, done
  );

  modport slave (
    output start, stall, mem_rd_data,
    input  mem_rd_en, mem_addr, data_out, data_enable, sof, eol, eof,
           row, col, window_valid, busy, done
  );
endinterface

// File: rtl/frame_pixel_streamer.sv
// Streams a frame from a 1-cycle-latency RAM as raster pixels with sof/eol/eof,
// row/col position and 7x7 window_valid; downstream stall pauses without loss.
module frame_pixel_streamer #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int WIN        = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  frame_pixel_streamer_if.master  strm_io
);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0]      WIN_COL   = COL_W'(WIN - 1);
  localparam logic [ROW_W-1:0]      WIN_ROW   = ROW_W'(WIN - 1);

  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_rd_en_q;
  logic                  rd_pending_q;
  // Two entries: a stall can catch both the returning read and the one issued just before it.
  logic [DATA_WIDTH-1:0] hold_q [2];
  logic [1:0]            hold_cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  de_q, sof_q, eol_q, eof_q, wv_q, busy_q, done_q;
  logic [ROW_W-1:0]      row_q, nrow_q;
  logic [COL_W-1:0]      col_q, ncol_q;

  logic                  issue_d, pop_d, direct_d, push_d, emit_d, last_pix_d;
  logic [DATA_WIDTH-1:0] pix_d;

  assign issue_d    = (state_q == S_READ) && !strm_io.stall && (hold_cnt_q == 2'd0);
  assign pop_d      = !strm_io.stall && (hold_cnt_q != 2'd0);
  assign direct_d   = !strm_io.stall && (hold_cnt_q == 2'd0) && rd_pending_q;
  assign push_d     = rd_pending_q && !direct_d;
  assign emit_d     = pop_d || direct_d;
  assign pix_d      = pop_d ? hold_q[0] : strm_io.mem_rd_data;
  assign last_pix_d = (nrow_q == LAST_ROW) && (ncol_q == LAST_COL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      mem_addr_q   <= '0;
      mem_rd_en_q  <= 1'b0;
      rd_pending_q <= 1'b0;
      hold_q[0]    <= '0;
      hold_q[1]    <= '0;
      hold_cnt_q   <= 2'd0;
      data_q       <= '0;
      de_q         <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      wv_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      nrow_q       <= '0;
      ncol_q       <= '0;
    end else begin
      done_q       <= (state_q == S_DONE);
      mem_rd_en_q  <= issue_d;
      rd_pending_q <= mem_rd_en_q;
      if (issue_d) begin
        mem_addr_q <= rd_addr_q;
        rd_addr_q  <= rd_addr_q + 1'b1;
      end

      if (push_d && pop_d) begin
        if (hold_cnt_q == 2'd1) begin
          hold_q[0] <= strm_io.mem_rd_data;
        end else begin
          hold_q[0] <= hold_q[1];
          hold_q[1] <= strm_io.mem_rd_data;
        end
      end else if (pop_d) begin
        hold_q[0]  <= hold_q[1];
        hold_cnt_q <= hold_cnt_q - 2'd1;
      end else if (push_d) begin
        if (hold_cnt_q == 2'd0) hold_q[0] <= strm_io.mem_rd_data;
        else                    hold_q[1] <= strm_io.mem_rd_data;
        hold_cnt_q <= hold_cnt_q + 2'd1;
      end

      de_q <= emit_d;
      if (emit_d) begin
        data_q <= pix_d;
        row_q  <= nrow_q;
        col_q  <= ncol_q;
        sof_q  <= (nrow_q == '0) && (ncol_q == '0);
        eol_q  <= (ncol_q == LAST_COL);
        eof_q  <= last_pix_d;
        wv_q   <= (nrow_q >= WIN_ROW) && (ncol_q >= WIN_COL);
        if (ncol_q == LAST_COL) begin
          ncol_q <= '0;
          nrow_q <= nrow_q + 1'b1;
        end else begin
          ncol_q <= ncol_q + 1'b1;
        end
      end else begin
        sof_q <= 1'b0;
        eol_q <= 1'b0;
        eof_q <= 1'b0;
        wv_q  <= 1'b0;
      end

      case (state_q)
        S_IDLE: if (strm_io.start) begin
          state_q   <= S_READ;
          busy_q    <= 1'b1;
          rd_addr_q <= '0;
          nrow_q    <= '0;
          ncol_q    <= '0;
          row_q     <= '0;
          col_q     <= '0;
        end
        S_READ:  if (issue_d && (rd_addr_q == LAST_ADDR)) state_q <= S_DRAIN;
        S_DRAIN: if (emit_d && last_pix_d) state_q <= S_DONE;
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign strm_io.mem_rd_en    = mem_rd_en_q;
  assign strm_io.mem_addr     = mem_addr_q;
  assign strm_io.data_out     = data_q;
  assign strm_io.data_enable  = de_q;
  assign strm_io.sof          = sof_q;
  assign strm_io.eol          = eol_q;
  assign strm_io.eof          = eof_q;
  assign strm_io.row          = row_q;
  assign strm_io.col          = col_q;
  assign strm_io.window_valid = wv_q;
  assign strm_io.busy         = busy_q;
  assign strm_io.done         = done_q;
endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Randomised-stall bench for frame_pixel_streamer on an 8x8 frame, checked every
// cycle against an index-based raster model of the expected pixel stream.
module tb_frame_pixel_streamer;
  localparam int W = 8, H = 8, DW = 8, AW = 6, WIN = 7, N = W * H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_pixel_streamer_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  frame_pixel_streamer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WIN(WIN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .strm_io (bus)
  );

  logic [DW-1:0] ram [N];
  logic [DW-1:0] ram_rd_q;
  always @(posedge clk) if (bus.mem_rd_en === 1'b1) ram_rd_q <= ram[bus.mem_addr];
  assign bus.mem_rd_data = ram_rd_q;

  int tests = 0, fails = 0, cyc = 0;
  bit stall_s, mon_en = 1'b0, prev_eof;
  int exp_k, exp_rd, pix_cnt, wv_cnt, sof_cnt, eol_cnt, eof_cnt, done_cnt, first_de, done_cyc;
  int wv_vals[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc++;
    stall_s = bus.stall;
  end

  // Model: the k-th emitted pixel is ram[k] at (k/W, k%W); reads go out as 0..N-1.
  always @(negedge clk) if (mon_en) begin
    if (bus.mem_rd_en) begin
      check("rd_while_stall", 64'(stall_s), 0);
      check("rd_addr", 64'(bus.mem_addr), 64'(exp_rd));
      exp_rd++;
    end
    if (bus.data_enable) begin
      check("de_after_stall", 64'(stall_s), 0);
      if (exp_k >= N) begin
        check("extra_pixel", 64'(exp_k), 64'(N - 1));
      end else begin
        check("pixel", 64'(bus.data_out), 64'(ram[exp_k]));
        check("row", 64'(bus.row), 64'(exp_k / W));
        check("col", 64'(bus.col), 64'(exp_k % W));
        check("sof", 64'(bus.sof), 64'(exp_k == 0));
        check("eol", 64'(bus.eol), 64'((exp_k % W) == W - 1));
        check("eof", 64'(bus.eof), 64'(exp_k == N - 1));
        check("window_valid", 64'(bus.window_valid),
              64'((exp_k / W) >= WIN - 1 && (exp_k % W) >= WIN - 1));
      end
      if (first_de < 0) first_de = cyc;
      if (bus.window_valid) begin
        wv_cnt++;
        wv_vals.push_back(int'(bus.data_out));
      end
      sof_cnt += int'(bus.sof);
      eol_cnt += int'(bus.eol);
      eof_cnt += int'(bus.eof);
      pix_cnt++;
      exp_k++;
    end else begin
      check("markers_idle", 64'({bus.sof, bus.eol, bus.eof, bus.window_valid}), 0);
    end
    if (bus.done) begin
      check("done_after_eof", 64'(prev_eof), 1);
      check("busy_at_done", 64'(bus.busy), 0);
      done_cnt++;
      done_cyc = cyc;
    end
    prev_eof = bus.data_enable && bus.eof;
  end

  task automatic run_frame(input int mode, input int restart_at, input string tag);
    int t0, stall_left;
    bit fired, trig;
    fired = 0; trig = 0; stall_left = 0;
    exp_k = 0; exp_rd = 0; pix_cnt = 0; wv_cnt = 0; sof_cnt = 0; eol_cnt = 0; eof_cnt = 0;
    done_cnt = 0; first_de = -1; done_cyc = -1; wv_vals.delete();
    bus.start = 1'b1;
    bus.stall = 1'b0;
    tick();
    t0 = cyc;
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 1);
    for (int n = 0; n < 2000 && bus.done !== 1'b1; n++) begin
      case (mode)
        1: begin
          if (stall_left > 0) begin
            bus.stall = 1'b1;
            stall_left--;
          end else if (!trig && bus.mem_rd_en && bus.mem_addr == AW'(10)) begin
            bus.stall = 1'b1;
            stall_left = 2;
            trig = 1;
          end else begin
            bus.stall = 1'b0;
          end
        end
        2:       bus.stall = ~bus.stall;
        3:       bus.stall = ($urandom_range(0, 3) == 0);
        default: bus.stall = 1'b0;
      endcase
      bus.start = (restart_at >= 0) && bus.data_enable && (bus.data_out == DW'(restart_at));
      if (bus.start) fired = 1;
      tick();
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check({tag, "_done_timeout"}, 64'(bus.done), 1);
    tick();
    check({tag, "_done_pulse"}, 64'(bus.done), 0);
    check({tag, "_busy_after"}, 64'(bus.busy), 0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 1);
    check({tag, "_pix_cnt"}, 64'(pix_cnt), 64'(N));
    check({tag, "_reads"}, 64'(exp_rd), 64'(N));
    check({tag, "_sof_cnt"}, 64'(sof_cnt), 1);
    check({tag, "_eol_cnt"}, 64'(eol_cnt), 64'(H));
    check({tag, "_eof_cnt"}, 64'(eof_cnt), 1);
    check({tag, "_wv_cnt"}, 64'(wv_cnt), 4);
    if (mode == 0) begin
      check({tag, "_latency"}, 64'(first_de - t0), 3);
      check({tag, "_frame_time"}, 64'(done_cyc - t0), 64'(N + 3));
    end
    if (mode == 2) check({tag, "_time_bound"}, 64'(done_cyc - t0 <= 2 * (N + 3) + 3), 1);
    if (mode == 1) check({tag, "_stall_hit"}, 64'(trig), 1);
    if (restart_at >= 0) check({tag, "_restart_pulsed"}, 64'(fired), 1);
    $display("[TB] frame %s mode=%0d pixels=%0d cycles=%0d", tag, mode, pix_cnt, done_cyc - t0);
  endtask

  initial begin
    int wv_exp[4];
    wv_exp = '{54, 55, 62, 63};
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    for (int i = 0; i < N; i++) ram[i] = DW'(i);
    repeat (3) tick();
    check("rst_de", 64'(bus.data_enable), 0);
    check("rst_rd_en", 64'(bus.mem_rd_en), 0);
    check("rst_addr", 64'(bus.mem_addr), 0);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_data", 64'(bus.data_out), 0);
    check("rst_rowcol", 64'({bus.row, bus.col}), 0);
    check("rst_marks", 64'({bus.sof, bus.eol, bus.eof, bus.window_valid}), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    run_frame(0, -1, "plain");
    check("wv_list_size", 64'(wv_vals.size()), 4);
    for (int i = 0; i < 4 && i < wv_vals.size(); i++) check("wv_pixel", 64'(wv_vals[i]), 64'(wv_exp[i]));

    run_frame(1, -1, "stall3");
    run_frame(2, -1, "toggle");
    run_frame(0, 20, "restart");
    run_frame(0, -1, "again");

    // Mid-frame reset at pixel 30
    exp_k = 0; exp_rd = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 200 && !(bus.data_enable && bus.data_out == DW'(30)); n++) tick();
    check("reached_px30", 64'(bus.data_enable && bus.data_out == DW'(30)), 1);
    reset = 1'b1;
    tick();
    exp_k = 0; exp_rd = 0;
    reset = 1'b0;
    check("mid_rst_de", 64'(bus.data_enable), 0);
    check("mid_rst_rd_en", 64'(bus.mem_rd_en), 0);
    check("mid_rst_busy", 64'(bus.busy), 0);
    check("mid_rst_data", 64'(bus.data_out), 0);
    check("mid_rst_rowcol", 64'({bus.row, bus.col}), 0);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("post_rst_quiet", 64'({bus.mem_rd_en, bus.data_enable}), 0);
    end
    run_frame(0, -1, "after_reset");

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) ram[i] = DW'($urandom);
      run_frame(3, -1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
